// File: rtl/spi_sram_pkg.sv
// spi_sram_pkg: shared constants, state encoding and frame-width helper for the SPI SRAM sequencer
package spi_sram_pkg;
    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_WRITE = 8'h02;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    function automatic int frame_w(input int addr_w, input int data_w);
        return 8 + addr_w + data_w;
    endfunction
endpackage

// File: rtl/spi_rr_arb2.sv
// spi_rr_arb2: two-way round-robin arbiter; ptr names the requester served last
module spi_rr_arb2 (
    input  logic [1:0] req,
    input  logic       en,
    input  logic       ptr,
    output logic [1:0] gnt
);
    always_comb gnt = !en ? 2'b00 : (&req) ? (ptr ? 2'b01 : 2'b10) : req;
endmodule

// File: rtl/spi_sram_sequencer.sv
// spi_sram_sequencer: arbitrates two byte requesters and runs one SPI mode-0
// {cmd, addr, data} frame per grant, returning read data with a one-cycle ack
module spi_sram_sequencer
    import spi_sram_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 8,
    parameter int HALF_DIV = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req,
    input  logic [1:0]        we,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic [1:0]        ack,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              ss,
    output logic              sck,
    output logic              mosi,
    input  logic              miso
);
    localparam int FW = frame_w(ADDR_W, DATA_W);
    localparam int CW = $clog2(FW);
    localparam int DW = $clog2(2 * HALF_DIV);
    localparam logic [DW-1:0] LO_END = DW'(HALF_DIV - 1);
    localparam logic [DW-1:0] HI_END = DW'(2 * HALF_DIV - 1);

    state_t            state;
    logic [FW-1:0]     sh;
    logic [FW-1:0]     word;
    logic [DATA_W-1:0] rx;
    logic [CW-1:0]     cnt;
    logic [DW-1:0]     dv;
    logic [1:0]        gnt;
    logic              ptr, win, rd, sel;

    spi_rr_arb2 u_arb (.req(req), .en(state == IDLE), .ptr(ptr), .gnt(gnt));

    always_comb begin
        sel  = gnt[1];
        word = {we[sel] ? CMD_WRITE : CMD_READ, sel ? addr1 : addr0, sel ? wdata1 : wdata0};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            sh    <= '0;
            rx    <= '0;
            cnt   <= '0;
            dv    <= '0;
            ptr   <= 1'b1;
            win   <= 1'b0;
            rd    <= 1'b0;
            ss    <= 1'b1;
            sck   <= 1'b0;
            mosi  <= 1'b0;
            ack   <= '0;
            rdata <= '0;
            busy  <= 1'b0;
        end else begin
            ack <= '0;
            case (state)
                IDLE: if (|gnt) begin
                    state <= SHIFT;
                    sh    <= word;
                    mosi  <= word[FW-1];
                    win   <= sel;
                    ptr   <= sel;
                    rd    <= !we[sel];
                    cnt   <= CW'(FW - 1);
                    dv    <= '0;
                    ss    <= 1'b0;
                    busy  <= 1'b1;
                end
                SHIFT: begin
                    dv <= (dv == HI_END) ? '0 : dv + 1'b1;
                    if (dv == LO_END) begin
                        sck <= 1'b1;
                        rx  <= {rx[DATA_W-2:0], miso};
                    end
                    // end of high phase: advance to the next bit or close the frame
                    if (dv == HI_END) begin
                        sck  <= 1'b0;
                        sh   <= sh << 1;
                        mosi <= (cnt == '0) ? 1'b0 : sh[FW-2];
                        cnt  <= cnt - 1'b1;
                        if (cnt == '0) begin
                            state <= DONE;
                            ss    <= 1'b1;
                            ack   <= win ? 2'b10 : 2'b01;
                            rdata <= rd ? rx : rdata;
                        end
                    end
                end
                DONE: begin
                    dv <= (dv == HI_END) ? '0 : dv + 1'b1;
                    if (dv == HI_END) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
